// File: rtl/alu_sequencer.sv
// Multi-cycle SM83 ALU instruction sequencer: decode, operand fetch, execute, register writeback.
// Optional ALU_SEQ_BACK_TO_BACK_EN: accept the next request during EXEC for A-only/no-destination ops.
module alu_sequencer (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_Req_Valid,
  output logic       o_Req_Ready,
  input  logic [7:0] i_Req_Opcode,
  input  logic       i_Req_CB,
  output logic       o_Op_Req,
  output logic [2:0] o_Op_Sel,
  output logic       o_Op_Imm,
  input  logic       i_Op_Valid,
  input  logic [7:0] i_Op_Data,
  output logic [1:0] o_ALU_Read,
  output logic [1:0] o_ALU_Write,
  output logic [7:0] o_ALU_Data,
  output logic [7:0] o_ALU_Opcode,
  output logic [7:0] o_ALU_Parameter,
  output logic [5:0] o_ALU_Function_Control,
  output logic       o_ALU_Save_Flags,
  input  logic [7:0] i_ALU_Reg_Data,
  input  logic [7:0] i_ALU_Result,
  output logic       o_Wb_Valid,
  output logic [2:0] o_Wb_Sel,
  output logic [7:0] o_Wb_Data,
  input  logic       i_Wb_Ready,
  output logic       o_Done,
  output logic       o_Illegal
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned FC_W   = 6;
  localparam int unsigned RW_W   = 2;

  localparam logic [FC_W-1:0] FC_MAIN = 6'b000001;
  localparam logic [FC_W-1:0] FC_INC  = 6'b000010;
  localparam logic [FC_W-1:0] FC_DEC  = 6'b000110;
  localparam logic [FC_W-1:0] FC_CB   = 6'b001000;
  localparam logic [FC_W-1:0] FC_ROTA = 6'b011000;
  localparam logic [FC_W-1:0] FC_MISC = 6'b100000;

  localparam logic [RW_W-1:0]  REG_A = 2'b01;
  localparam logic [SEL_W-1:0] SEL_A = 3'd7;
  localparam logic [SEL_W-1:0] SEL_HL = 3'd6;

`ifdef ALU_SEQ_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WRITE} state_t;
  typedef enum logic [1:0] {DST_NONE, DST_A, DST_REG} dst_t;

  state_t            state;
  logic [DATA_W-1:0] opcode_q;
  logic [FC_W-1:0]   fc_q;
  logic [SEL_W-1:0]  sel_q;
  dst_t              dst_q;
  logic              src_a_q;

  logic              dec_legal;
  logic [FC_W-1:0]   dec_fc;
  logic [SEL_W-1:0]  dec_sel;
  logic              dec_imm;
  logic              dec_misc;
  dst_t              dec_dst;
  logic              dec_src_a;
  logic              accept;

  assign accept    = i_Req_Valid && o_Req_Ready;
  assign dec_src_a = !dec_imm && (dec_sel == SEL_A);

  // A is written straight from the ALU result during the execute cycle
  assign o_ALU_Data = (o_ALU_Write == REG_A) ? i_ALU_Result : '0;

  // Classify the incoming request into an ALU unit, operand source and destination
  always_comb begin : decode
    dec_legal = 1'b0;
    dec_fc    = '0;
    dec_sel   = i_Req_Opcode[2:0];
    dec_imm   = 1'b0;
    dec_misc  = 1'b0;
    dec_dst   = DST_NONE;
    if (i_Req_CB) begin
      dec_legal = 1'b1;
      dec_fc    = FC_CB;
      if (i_Req_Opcode[7:6] != 2'b01)
        dec_dst = (dec_sel == SEL_A) ? DST_A : DST_REG;
    end else if (i_Req_Opcode[7:6] == 2'b10) begin
      dec_legal = 1'b1;
      dec_fc    = FC_MAIN;
      dec_dst   = (i_Req_Opcode[5:3] == 3'd7) ? DST_NONE : DST_A;
    end else if (i_Req_Opcode[7:6] == 2'b11 && i_Req_Opcode[2:0] == SEL_HL) begin
      dec_legal = 1'b1;
      dec_fc    = FC_MAIN;
      dec_imm   = 1'b1;
      dec_dst   = (i_Req_Opcode[5:3] == 3'd7) ? DST_NONE : DST_A;
    end else if (i_Req_Opcode[7:6] == 2'b00 && i_Req_Opcode[2:1] == 2'b10) begin
      dec_legal = 1'b1;
      dec_fc    = i_Req_Opcode[0] ? FC_DEC : FC_INC;
      dec_sel   = i_Req_Opcode[5:3];
      dec_dst   = (i_Req_Opcode[5:3] == SEL_A) ? DST_A : DST_REG;
    end else if (i_Req_Opcode[7:5] == 3'b000 && i_Req_Opcode[2:0] == 3'b111) begin
      dec_legal = 1'b1;
      dec_fc    = FC_ROTA;
      dec_sel   = SEL_A;
      dec_dst   = DST_A;
    end else if (i_Req_Opcode[7:5] == 3'b001 && i_Req_Opcode[2:0] == 3'b111) begin
      dec_legal = 1'b1;
      dec_fc    = FC_MISC;
      dec_sel   = SEL_A;
      dec_misc  = 1'b1;
      dec_dst   = DST_A;
    end
  end

  // Sequencer FSM with registered outputs; an accepted request overrides the per-state update
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      state                  <= IDLE;
      opcode_q               <= '0;
      fc_q                   <= '0;
      sel_q                  <= '0;
      dst_q                  <= DST_NONE;
      src_a_q                <= 1'b0;
      o_Req_Ready            <= 1'b0;
      o_Op_Req               <= 1'b0;
      o_Op_Sel               <= '0;
      o_Op_Imm               <= 1'b0;
      o_ALU_Read             <= '0;
      o_ALU_Write            <= '0;
      o_ALU_Opcode           <= '0;
      o_ALU_Parameter        <= '0;
      o_ALU_Function_Control <= '0;
      o_ALU_Save_Flags       <= 1'b0;
      o_Wb_Valid             <= 1'b0;
      o_Wb_Sel               <= '0;
      o_Wb_Data              <= '0;
      o_Done                 <= 1'b0;
      o_Illegal              <= 1'b0;
    end else begin
      o_Done                 <= 1'b0;
      o_Illegal              <= 1'b0;
      o_Req_Ready            <= 1'b0;
      o_ALU_Read             <= '0;
      o_ALU_Write            <= '0;
      o_ALU_Opcode           <= '0;
      o_ALU_Parameter        <= '0;
      o_ALU_Function_Control <= '0;
      o_ALU_Save_Flags       <= 1'b0;

      case (state)
        IDLE: o_Req_Ready <= 1'b1;

        FETCH: begin
          if (src_a_q || i_Op_Valid) begin
            state                  <= EXEC;
            o_Op_Req               <= 1'b0;
            o_Op_Sel               <= '0;
            o_Op_Imm               <= 1'b0;
            o_ALU_Opcode           <= opcode_q;
            o_ALU_Parameter        <= src_a_q ? i_ALU_Reg_Data : i_Op_Data;
            o_ALU_Function_Control <= fc_q;
            o_ALU_Save_Flags       <= 1'b1;
            o_ALU_Write            <= (dst_q == DST_A) ? REG_A : '0;
            o_Req_Ready            <= B2B && (dst_q != DST_REG);
          end
        end

        EXEC: begin
          if (dst_q == DST_REG) begin
            state      <= WRITE;
            o_Wb_Valid <= 1'b1;
            o_Wb_Sel   <= sel_q;
            o_Wb_Data  <= i_ALU_Result;
          end else begin
            state       <= IDLE;
            o_Done      <= 1'b1;
            o_Req_Ready <= 1'b1;
          end
        end

        WRITE: begin
          if (i_Wb_Ready) begin
            state       <= IDLE;
            o_Wb_Valid  <= 1'b0;
            o_Wb_Sel    <= '0;
            o_Wb_Data   <= '0;
            o_Done      <= 1'b1;
            o_Req_Ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      if (accept) begin
        opcode_q <= i_Req_Opcode;
        fc_q     <= dec_fc;
        sel_q    <= dec_sel;
        dst_q    <= dec_dst;
        src_a_q  <= dec_src_a;
        if (!dec_legal) begin
          state       <= IDLE;
          o_Illegal   <= 1'b1;
          o_Req_Ready <= 1'b1;
        end else if (dec_misc) begin
          // Misc ops work on A inside the ALU, so no operand is fetched
          state                  <= EXEC;
          o_Req_Ready            <= B2B;
          o_ALU_Opcode           <= i_Req_Opcode;
          o_ALU_Parameter        <= '0;
          o_ALU_Function_Control <= dec_fc;
          o_ALU_Save_Flags       <= 1'b1;
          o_ALU_Write            <= REG_A;
        end else begin
          state       <= FETCH;
          o_Req_Ready <= 1'b0;
          if (dec_src_a) begin
            o_ALU_Read <= REG_A;
          end else begin
            o_Op_Req <= 1'b1;
            o_Op_Sel <= dec_sel;
            o_Op_Imm <= dec_imm;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer: emulates the ALU (A/F) and register file, scores against an opcode-level model.
module tb_alu_sequencer;

  logic       i_Clk = 1'b0;
  logic       i_Rst_N = 1'b0;
  logic       i_Req_Valid = 1'b0;
  logic       o_Req_Ready;
  logic [7:0] i_Req_Opcode = '0;
  logic       i_Req_CB = 1'b0;
  logic       o_Op_Req;
  logic [2:0] o_Op_Sel;
  logic       o_Op_Imm;
  logic       i_Op_Valid = 1'b0;
  logic [7:0] i_Op_Data = '0;
  logic [1:0] o_ALU_Read;
  logic [1:0] o_ALU_Write;
  logic [7:0] o_ALU_Data;
  logic [7:0] o_ALU_Opcode;
  logic [7:0] o_ALU_Parameter;
  logic [5:0] o_ALU_Function_Control;
  logic       o_ALU_Save_Flags;
  logic [7:0] i_ALU_Reg_Data;
  logic [7:0] i_ALU_Result;
  logic       o_Wb_Valid;
  logic [2:0] o_Wb_Sel;
  logic [7:0] o_Wb_Data;
  logic       i_Wb_Ready = 1'b0;
  logic       o_Done;
  logic       o_Illegal;

  always #5 i_Clk = ~i_Clk;

  alu_sequencer dut (
    .i_Clk(i_Clk), .i_Rst_N(i_Rst_N),
    .i_Req_Valid(i_Req_Valid), .o_Req_Ready(o_Req_Ready),
    .i_Req_Opcode(i_Req_Opcode), .i_Req_CB(i_Req_CB),
    .o_Op_Req(o_Op_Req), .o_Op_Sel(o_Op_Sel), .o_Op_Imm(o_Op_Imm),
    .i_Op_Valid(i_Op_Valid), .i_Op_Data(i_Op_Data),
    .o_ALU_Read(o_ALU_Read), .o_ALU_Write(o_ALU_Write), .o_ALU_Data(o_ALU_Data),
    .o_ALU_Opcode(o_ALU_Opcode), .o_ALU_Parameter(o_ALU_Parameter),
    .o_ALU_Function_Control(o_ALU_Function_Control), .o_ALU_Save_Flags(o_ALU_Save_Flags),
    .i_ALU_Reg_Data(i_ALU_Reg_Data), .i_ALU_Result(i_ALU_Result),
    .o_Wb_Valid(o_Wb_Valid), .o_Wb_Sel(o_Wb_Sel), .o_Wb_Data(o_Wb_Data),
    .i_Wb_Ready(i_Wb_Ready), .o_Done(o_Done), .o_Illegal(o_Illegal)
  );

  localparam int U_NONE = 0, U_MAIN = 1, U_INC = 2, U_DEC = 3, U_ROTA = 4, U_CB = 5, U_MISC = 6;
  localparam int D_NONE = 0, D_A = 1, D_REG = 2;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SM83 ALU behaviour: returns {result, flags}; flags = Z N H C 0000
  function automatic logic [15:0] alu_fn(input int unit, input logic [7:0] op,
                                         input logic [7:0] a, input logic [7:0] f, input logic [7:0] b);
    int ai, bi, ci, t, k, adj;
    logic [7:0] r;
    logic z, n, h, c;
    ai = int'(a); bi = int'(b);
    r = a; z = f[7]; n = f[6]; h = f[5]; c = f[4];
    k = int'(op[5:3]);
    case (unit)
      U_MAIN: begin
        ci = (k == 1 || k == 3) ? int'(f[4]) : 0;
        if (k <= 1) begin
          t = ai + bi + ci; r = 8'(t); n = 1'b0;
          h = ((ai % 16) + (bi % 16) + ci) > 15; c = t > 255;
        end else if (k == 2 || k == 3 || k == 7) begin
          t = ai - bi - ci; r = 8'(t); n = 1'b1;
          h = (ai % 16) < ((bi % 16) + ci); c = ai < (bi + ci);
        end else if (k == 4) begin
          r = a & b; n = 1'b0; h = 1'b1; c = 1'b0;
        end else if (k == 5) begin
          r = a ^ b; n = 1'b0; h = 1'b0; c = 1'b0;
        end else begin
          r = a | b; n = 1'b0; h = 1'b0; c = 1'b0;
        end
        z = (r == 8'h00);
      end
      U_INC: begin r = 8'(bi + 1); z = (r == 8'h00); n = 1'b0; h = (b[3:0] == 4'hF); end
      U_DEC: begin r = 8'(bi - 1); z = (r == 8'h00); n = 1'b1; h = (b[3:0] == 4'h0); end
      U_ROTA: begin
        case (op[4:3])
          2'd0: begin r = {b[6:0], b[7]}; c = b[7]; end
          2'd1: begin r = {b[0], b[7:1]}; c = b[0]; end
          2'd2: begin r = {b[6:0], f[4]}; c = b[7]; end
          default: begin r = {f[4], b[7:1]}; c = b[0]; end
        endcase
        z = 1'b0; n = 1'b0; h = 1'b0;
      end
      U_CB: begin
        case (op[7:6])
          2'b00: begin
            case (k)
              0: begin r = {b[6:0], b[7]}; c = b[7]; end
              1: begin r = {b[0], b[7:1]}; c = b[0]; end
              2: begin r = {b[6:0], f[4]}; c = b[7]; end
              3: begin r = {f[4], b[7:1]}; c = b[0]; end
              4: begin r = {b[6:0], 1'b0}; c = b[7]; end
              5: begin r = {b[7], b[7:1]}; c = b[0]; end
              6: begin r = {b[3:0], b[7:4]}; c = 1'b0; end
              default: begin r = {1'b0, b[7:1]}; c = b[0]; end
            endcase
            z = (r == 8'h00); n = 1'b0; h = 1'b0;
          end
          2'b01: begin r = b; z = !b[op[5:3]]; n = 1'b0; h = 1'b1; end
          2'b10: r = b & ~(8'h01 << op[5:3]);
          default: r = b | (8'h01 << op[5:3]);
        endcase
      end
      U_MISC: begin
        case (op[4:3])
          2'd0: begin
            adj = 0;
            if (!n) begin
              if (c || ai > 153) begin adj += 96; c = 1'b1; end
              if (h || (ai % 16) > 9) adj += 6;
              t = ai + adj;
            end else begin
              if (c) adj += 96;
              if (h) adj += 6;
              t = ai - adj;
            end
            r = 8'(t); z = (r == 8'h00); h = 1'b0;
          end
          2'd1: begin r = ~a; n = 1'b1; h = 1'b1; end
          2'd2: begin n = 1'b0; h = 1'b0; c = 1'b1; end
          default: begin n = 1'b0; h = 1'b0; c = !c; end
        endcase
      end
      default: return 16'hEEEE;
    endcase
    return {r, z, n, h, c, 4'b0000};
  endfunction

  // ALU / register-file environment: owns A and F, answers the DUT's control lines
  logic [7:0]  alu_a = '0, alu_f = '0;
  logic        load_en = 1'b0;
  logic [7:0]  load_a = '0, load_f = '0;
  int          save_cnt = 0, write_cnt = 0;
  logic [5:0]  fc_seen = '0;
  int          env_unit;
  logic [15:0] env_out;

  always_comb begin
    case (o_ALU_Function_Control)
      6'b000001: env_unit = U_MAIN;
      6'b000010: env_unit = U_INC;
      6'b000110: env_unit = U_DEC;
      6'b011000: env_unit = U_ROTA;
      6'b001000: env_unit = U_CB;
      6'b100000: env_unit = U_MISC;
      default:   env_unit = U_NONE;
    endcase
    env_out = alu_fn(env_unit, o_ALU_Opcode, alu_a, alu_f, o_ALU_Parameter);
  end

  assign i_ALU_Result   = env_out[15:8];
  assign i_ALU_Reg_Data = (o_ALU_Read == 2'b01) ? alu_a : ((o_ALU_Read == 2'b10) ? alu_f : 8'h00);

  always @(posedge i_Clk) begin
    if (load_en) begin
      alu_a <= load_a;
      alu_f <= load_f;
    end else begin
      if (o_ALU_Save_Flags) begin
        alu_f     <= env_out[7:0];
        save_cnt  <= save_cnt + 1;
        fc_seen   <= o_ALU_Function_Control;
      end
      if (o_ALU_Write == 2'b01) begin
        alu_a     <= o_ALU_Data;
        write_cnt <= write_cnt + 1;
      end
    end
  end

  logic [7:0] model_a = '0, model_f = '0;

  // Opcode-level reference decode from the instruction-class table
  task automatic ref_decode(input logic [7:0] op, input logic cb, output bit legal, output int unit,
                            output bit ext, output logic [2:0] sel, output bit imm, output int dst);
    legal = 1'b1; imm = 1'b0; ext = 1'b1; sel = op[2:0]; dst = D_A; unit = U_NONE;
    if (cb) begin
      unit = U_CB;
      dst  = (op inside {[8'h40:8'h7F]}) ? D_NONE : D_REG;
    end else if (op inside {[8'h80:8'hBF]}) begin
      unit = U_MAIN;
      dst  = (op[5:3] == 3'd7) ? D_NONE : D_A;
    end else if (op >= 8'hC0 && op[2:0] == 3'd6) begin
      unit = U_MAIN; imm = 1'b1;
      dst  = (op[5:3] == 3'd7) ? D_NONE : D_A;
    end else if (op < 8'h40 && (op[2:0] == 3'd4 || op[2:0] == 3'd5)) begin
      unit = (op[2:0] == 3'd4) ? U_INC : U_DEC;
      sel  = op[5:3]; dst = D_REG;
    end else if (op inside {8'h07, 8'h0F, 8'h17, 8'h1F}) begin
      unit = U_ROTA; sel = 3'd7;
    end else if (op inside {8'h27, 8'h2F, 8'h37, 8'h3F}) begin
      unit = U_MISC; sel = 3'd7; ext = 1'b0;
    end else begin
      legal = 1'b0;
    end
    if (dst == D_REG && sel == 3'd7) dst = D_A;
    if (!imm && sel == 3'd7) ext = 1'b0;
  endtask

  function automatic logic [5:0] unit_fc(input int unit);
    case (unit)
      U_MAIN: return 6'b000001;
      U_INC:  return 6'b000010;
      U_DEC:  return 6'b000110;
      U_ROTA: return 6'b011000;
      U_CB:   return 6'b001000;
      U_MISC: return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic load_af(input logic [7:0] a, input logic [7:0] f);
    @(negedge i_Clk);
    load_a = a; load_f = f; load_en = 1'b1;
    @(negedge i_Clk);
    load_en = 1'b0;
    model_a = a; model_f = f;
  endtask

  // Issue one instruction, service operand/writeback handshakes, and score the outcome
  task automatic run_instr(input logic [7:0] op, input logic cb, input logic [7:0] opnd,
                           input int op_wait, input int wb_wait);
    bit legal, ext, imm, ill, wb_ok;
    int unit, dst, cyc, done_cyc, opreq_n, wb_n, s0, w0, guard, exp_lat;
    logic [2:0] sel;
    logic [15:0] exp_rf;
    ref_decode(op, cb, legal, unit, ext, sel, imm, dst);
    exp_rf = alu_fn(unit, op, model_a, model_f, ext ? opnd : model_a);
    guard = 0;
    while (!o_Req_Ready && guard < 20) begin
      @(negedge i_Clk);
      guard++;
    end
    check("req_ready", {63'd0, o_Req_Ready}, 64'd1);
    s0 = save_cnt; w0 = write_cnt;
    i_Req_Valid = 1'b1; i_Req_Opcode = op; i_Req_CB = cb;
    @(negedge i_Clk);
    i_Req_Valid = 1'b0;
    cyc = 1; done_cyc = 0; ill = 1'b0; opreq_n = 0; wb_n = 0; wb_ok = 1'b1;
    while (cyc < 60) begin
      i_Op_Valid = 1'b0; i_Wb_Ready = 1'b0; i_Op_Data = 8'($urandom);
      if (o_Op_Req) begin
        if (opreq_n == 0) check("op_sel_imm", {60'd0, o_Op_Sel, o_Op_Imm}, {60'd0, sel, imm});
        if (opreq_n == op_wait) begin i_Op_Valid = 1'b1; i_Op_Data = opnd; end
        opreq_n++;
      end
      if (o_Wb_Valid) begin
        if ({o_Wb_Sel, o_Wb_Data} !== {sel, exp_rf[15:8]}) wb_ok = 1'b0;
        if (wb_n == wb_wait) i_Wb_Ready = 1'b1;
        wb_n++;
      end
      if (o_Illegal) ill = 1'b1;
      if (o_Done) done_cyc = cyc;
      if (o_Done || o_Illegal) break;
      @(negedge i_Clk);
      cyc++;
    end
    i_Op_Valid = 1'b0; i_Wb_Ready = 1'b0;
    if (!legal) begin
      check("illegal_pulse", {62'd0, ill, 1'(cyc == 1)}, 64'd3);
      check("illegal_no_save", 64'(save_cnt - s0), 64'd0);
    end else begin
      exp_lat = ((unit == U_MISC) ? 2 : 3) + (ext ? op_wait : 0) + ((dst == D_REG) ? 1 + wb_wait : 0);
      check("latency", 64'(done_cyc), 64'(exp_lat));
      check("no_illegal", {63'd0, ill}, 64'd0);
      check("save_count", 64'(save_cnt - s0), 64'd1);
      check("func_ctrl", {58'd0, fc_seen}, {58'd0, unit_fc(unit)});
      check("a_write_count", 64'(write_cnt - w0), (dst == D_A) ? 64'd1 : 64'd0);
      check("op_req_cycles", 64'(opreq_n), ext ? 64'(op_wait + 1) : 64'd0);
      check("wb_cycles", 64'(wb_n), (dst == D_REG) ? 64'(wb_wait + 1) : 64'd0);
      if (dst == D_REG) check("wb_sel_data_stable", {63'd0, wb_ok}, 64'd1);
      model_f = exp_rf[7:0];
      if (dst == D_A) model_a = exp_rf[15:8];
    end
    check("reg_af", {48'd0, alu_a, alu_f}, {48'd0, model_a, model_f});
  endtask

  function automatic logic [54:0] all_outs();
    return {o_Req_Ready, o_Op_Req, o_Op_Sel, o_Op_Imm, o_ALU_Read, o_ALU_Write, o_ALU_Data,
            o_ALU_Opcode, o_ALU_Parameter, o_ALU_Function_Control, o_ALU_Save_Flags,
            o_Wb_Valid, o_Wb_Sel, o_Wb_Data, o_Done, o_Illegal};
  endfunction

  initial begin
    logic [7:0] keep_a, keep_f, rop;
    int s0, cls;
    load_af(8'h3A, 8'h00);
    check("reset_outputs", 64'(all_outs()), 64'd0);
    @(negedge i_Clk);
    i_Rst_N = 1'b1;
    #1 check("ready_at_release", {63'd0, o_Req_Ready}, 64'd0);
    @(posedge i_Clk);
    #1 check("ready_after_release", {63'd0, o_Req_Ready}, 64'd1);
    @(negedge i_Clk);

    // ADD A,B: 0x3A + 0xC6
    run_instr(8'h80, 1'b0, 8'hC6, 0, 0);
    // INC B with 0xFF and a stalled register file
    run_instr(8'h04, 1'b0, 8'hFF, 0, 4);
    // BIT 7,H on a zero bit, then CP 0x10 with A=0x10
    run_instr(8'h7C, 1'b1, 8'h00, 1, 0);
    load_af(8'h10, model_f);
    run_instr(8'hFE, 1'b0, 8'h10, 0, 0);
    // CPL with A=0x5A
    load_af(8'h5A, 8'h00);
    run_instr(8'h2F, 1'b0, 8'h00, 0, 0);
    // Rotate and CB on A, (HL) destination
    run_instr(8'h17, 1'b0, 8'h00, 0, 0);
    run_instr(8'h37, 1'b1, 8'h00, 0, 0);
    run_instr(8'h35, 1'b0, 8'h10, 2, 1);
    // Illegal opcode
    run_instr(8'h00, 1'b0, 8'h00, 0, 0);

    // Reset in the middle of ADD A,C fetch
    keep_a = alu_a; keep_f = alu_f; s0 = save_cnt;
    i_Req_Valid = 1'b1; i_Req_Opcode = 8'h81; i_Req_CB = 1'b0;
    @(negedge i_Clk);
    i_Req_Valid = 1'b0;
    check("fetch_op_req", {63'd0, o_Op_Req}, 64'd1);
    i_Rst_N = 1'b0;
    #1 check("midreset_outputs", 64'(all_outs()), 64'd0);
    repeat (2) @(negedge i_Clk);
    check("midreset_af", {48'd0, alu_a, alu_f}, {48'd0, keep_a, keep_f});
    check("midreset_no_save", 64'(save_cnt - s0), 64'd0);
    i_Rst_N = 1'b1;
    #1 check("ready_at_release2", {63'd0, o_Req_Ready}, 64'd0);
    @(posedge i_Clk);
    #1 check("ready_after_release2", {63'd0, o_Req_Ready}, 64'd1);
    @(negedge i_Clk);

    // Random instruction mix over every class plus random bytes
    for (int i = 0; i < 150; i++) begin
      cls = int'($urandom_range(0, 6));
      rop = 8'($urandom);
      case (cls)
        0: rop = {2'b10, rop[5:0]};
        1: rop = {2'b11, rop[5:3], 3'b110};
        2: rop = {2'b00, rop[5:3], 2'b10, rop[0]};
        3: rop = {3'b000, rop[4:3], 3'b111};
        5: rop = {3'b001, rop[4:3], 3'b111};
        default: ;
      endcase
      if (i % 25 == 0) load_af(8'($urandom), {4'($urandom), 4'h0});
      run_instr(rop, 1'(cls == 4), 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
